// File: rtl/ysyx_24100027_idu_issue_if.sv
// Issue channel from IDU to EXU: one valid/ready slot carrying decoded operands.
// IDU_ILLEGAL_TRAP_EN adds the out_illegal flag to the channel.
interface ysyx_24100027_idu_issue_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      aluctr;
    logic [XLEN-1:0] out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic            out_rd_wen;
    logic [2:0]      out_cls;
`ifdef IDU_ILLEGAL_TRAP_EN
    logic            out_illegal;

    modport master (
        output out_valid, alu_a, alu_b, aluctr, out_rs2, out_imm, out_pc,
               out_rd, out_rd_wen, out_cls, out_illegal,
        input  out_ready
    );
    modport slave (
        input  out_valid, alu_a, alu_b, aluctr, out_rs2, out_imm, out_pc,
               out_rd, out_rd_wen, out_cls, out_illegal,
        output out_ready
    );
`else
    modport master (
        output out_valid, alu_a, alu_b, aluctr, out_rs2, out_imm, out_pc,
               out_rd, out_rd_wen, out_cls,
        input  out_ready
    );
    modport slave (
        input  out_valid, alu_a, alu_b, aluctr, out_rs2, out_imm, out_pc,
               out_rd, out_rd_wen, out_cls,
        output out_ready
    );
`endif
endinterface

// File: rtl/ysyx_24100027_idu_issue.sv
// RV32I decode/issue stage: decode, operand select, one registered issue slot, RAW scoreboard.
// Define IDU_ILLEGAL_TRAP_EN to issue unknown encodings as cls 7 and lock intake until reset.
module ysyx_24100027_idu_issue #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    ysyx_24100027_idu_issue_if.master iss,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_JAL    = 3'd4;
    localparam logic [2:0] CLS_JALR   = 3'd5;
    localparam logic [2:0] CLS_SYS    = 3'd6;
`ifdef IDU_ILLEGAL_TRAP_EN
    localparam logic [2:0] CLS_ILL    = 3'd7;
`endif

    typedef struct packed {
        logic [XLEN-1:0] alu_a;
        logic [XLEN-1:0] alu_b;
        logic [3:0]      aluctr;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [2:0]      cls;
    } issue_t;

    // funct3 maps straight onto aluctr[2:0]; only sltu needs remapping
    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        return (f3 == 3'b011) ? 4'b1010 : {alt, f3};
    endfunction

    logic [6:0]      opc;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc = in_inst[6:0];
    assign rd  = in_inst[11:7];
    assign f3  = in_inst[14:12];
    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];
    assign f7  = in_inst[31:25];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

    issue_t          dec, slot;
    logic            rs1_used, rs2_used, dec_wen, dec_illegal;
    logic            slot_valid, hazard, fire, locked;
    logic [NREG-1:0] sb, sb_nxt;

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rd      = rd;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        dec_wen     = 1'b0;
        dec_illegal = 1'b0;
        case (opc)
            OPC_OP: begin
                dec_illegal = !((f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)));
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
                dec.alu_a   = rf_rdata1;
                dec.alu_b   = rf_rdata2;
                dec.rs2     = rf_rdata2;
                dec.aluctr  = alu_code(f3, f7[5]);
                dec_wen     = 1'b1;
            end
            OPC_IMM: begin
                if (f3 == 3'd1)
                    dec_illegal = (f7 != 7'b0);
                else if (f3 == 3'd5)
                    dec_illegal = (f7 != 7'b0) && (f7 != 7'b0100000);
                rs1_used   = 1'b1;
                dec.imm    = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, in_inst[24:20]} : imm_i;
                dec.alu_a  = rf_rdata1;
                dec.alu_b  = dec.imm;
                dec.aluctr = alu_code(f3, (f3 == 3'd5) && f7[5]);
                dec_wen    = 1'b1;
            end
            OPC_LOAD: begin
                dec_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
                rs1_used    = 1'b1;
                dec.imm     = imm_i;
                dec.alu_a   = rf_rdata1;
                dec.alu_b   = imm_i;
                dec.cls     = CLS_LOAD;
                dec_wen     = 1'b1;
            end
            OPC_STORE: begin
                dec_illegal = (f3 > 3'd2);
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
                dec.imm     = imm_s;
                dec.alu_a   = rf_rdata1;
                dec.alu_b   = imm_s;
                dec.rs2     = rf_rdata2;
                dec.cls     = CLS_STORE;
            end
            OPC_BRANCH: begin
                dec_illegal = (f3 == 3'd2) || (f3 == 3'd3);
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
                dec.imm     = imm_b;
                dec.alu_a   = rf_rdata1;
                dec.alu_b   = rf_rdata2;
                dec.rs2     = rf_rdata2;
                dec.aluctr  = !f3[2] ? 4'b1000 : (f3[1] ? 4'b1010 : 4'b0010);
                dec.cls     = CLS_BRANCH;
            end
            OPC_LUI: begin
                dec.imm    = imm_u;
                dec.alu_b  = imm_u;
                dec.aluctr = 4'b0011;
                dec_wen    = 1'b1;
            end
            OPC_AUIPC: begin
                dec.imm   = imm_u;
                dec.alu_a = in_pc;
                dec.alu_b = imm_u;
                dec_wen   = 1'b1;
            end
            OPC_JAL: begin
                dec.imm   = imm_j;
                dec.alu_a = in_pc;
                dec.alu_b = 32'd4;
                dec.cls   = CLS_JAL;
                dec_wen   = 1'b1;
            end
            OPC_JALR: begin
                dec_illegal = (f3 != 3'd0);
                rs1_used    = 1'b1;
                dec.imm     = imm_i;
                dec.alu_a   = rf_rdata1;
                dec.alu_b   = imm_i;
                dec.cls     = CLS_JALR;
                dec_wen     = 1'b1;
            end
            OPC_SYS: begin
                // CSR ops read rs1 (non-immediate forms) and write rd; ecall/ebreak do neither
                dec_illegal = (f3 == 3'd4);
                rs1_used    = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3);
                dec.imm     = imm_i;
                dec.alu_a   = rf_rdata1;
                dec.alu_b   = imm_i;
                dec.cls     = CLS_SYS;
                dec_wen     = (f3 != 3'd0);
            end
            OPC_FENCE: begin
                dec_illegal = (f3 > 3'd1);
                dec.cls     = CLS_SYS;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec      = '0;
            dec.pc   = in_pc;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
            dec_wen  = 1'b0;
`ifdef IDU_ILLEGAL_TRAP_EN
            dec.cls  = CLS_ILL;
`endif
        end
        dec.rd_wen = dec_wen && (dec.rd != 5'd0);
    end

    // no wb bypass: a retire in the same cycle still stalls the reader one cycle
    assign hazard   = (rs1_used && sb[rs1]) || (rs2_used && sb[rs2]);
    assign in_ready = rst_n && !hazard && !locked && (!slot_valid || iss.out_ready);
    assign fire     = in_valid && in_ready;

    always_comb begin
        sb_nxt = sb;
        if (wb_valid && wb_rd != 5'd0)
            sb_nxt[wb_rd] = 1'b0;
        if (fire && dec.rd_wen)
            sb_nxt[dec.rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= 1'b0;
            slot       <= '0;
            sb         <= '0;
        end else begin
            sb <= sb_nxt;
            if (fire) begin
                slot_valid <= 1'b1;
                slot       <= dec;
            end else if (iss.out_ready) begin
                slot_valid <= 1'b0;
            end
        end
    end

`ifdef IDU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            locked <= 1'b0;
        else if (fire && dec_illegal)
            locked <= 1'b1;
    end
    assign iss.out_illegal = (slot.cls == CLS_ILL);
`else
    assign locked = 1'b0;
`endif

    assign iss.out_valid  = slot_valid;
    assign iss.alu_a      = slot.alu_a;
    assign iss.alu_b      = slot.alu_b;
    assign iss.aluctr     = slot.aluctr;
    assign iss.out_rs2    = slot.rs2;
    assign iss.out_imm    = slot.imm;
    assign iss.out_pc     = slot.pc;
    assign iss.out_rd     = slot.rd;
    assign iss.out_rd_wen = slot.rd_wen;
    assign iss.out_cls    = slot.cls;
endmodule

// File: tb/tb_ysyx_24100027_idu_issue.sv
// Scoreboard bench for ysyx_24100027_idu_issue: expected issue records queued on fire, checked on consume.
module tb_ysyx_24100027_idu_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_inst, in_pc;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] regs [32];

    always #5 clk = ~clk;

    ysyx_24100027_idu_issue_if iss ();

    ysyx_24100027_idu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .iss(iss), .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [2:0]  cls;
    } exp_t;

    exp_t q[$];
    exp_t mon_e, mon_g;
    int   tests = 0;
    int   fails = 0;

`ifdef IDU_ILLEGAL_TRAP_EN
    localparam logic [2:0] ILL_CLS = 3'd7;
`else
    localparam logic [2:0] ILL_CLS = 3'd0;
`endif

    function automatic exp_t mk(input logic [31:0] a, b, input logic [3:0] ctl,
                                input logic [31:0] rs2, imm, pc, input logic [4:0] rd,
                                input logic wen, input logic [2:0] cls);
        return {a, b, ctl, rs2, imm, pc, rd, wen, cls};
    endfunction

    // consume-side scoreboard: one record per out_valid & out_ready edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && iss.out_valid === 1'b1 && iss.out_ready === 1'b1) begin
            tests++;
            mon_g = {iss.alu_a, iss.alu_b, iss.aluctr, iss.out_rs2, iss.out_imm, iss.out_pc,
                     iss.out_rd, iss.out_rd_wen, iss.out_cls};
            if (q.size() == 0) begin
                fails++;
                $display("FAIL issue_unexpected got=%h", mon_g);
            end else begin
                mon_e = q.pop_front();
                if (mon_g !== mon_e) begin
                    fails++;
                    $display("FAIL issue_pc%h got a=%h b=%h ctl=%b rs2=%h imm=%h rd=%0d wen=%b cls=%0d want a=%h b=%h ctl=%b rs2=%h imm=%h rd=%0d wen=%b cls=%0d",
                             mon_e.pc, mon_g.a, mon_g.b, mon_g.ctl, mon_g.rs2, mon_g.imm, mon_g.rd, mon_g.wen, mon_g.cls,
                             mon_e.a, mon_e.b, mon_e.ctl, mon_e.rs2, mon_e.imm, mon_e.rd, mon_e.wen, mon_e.cls);
                end
`ifdef IDU_ILLEGAL_TRAP_EN
                tests++;
                if (iss.out_illegal !== (mon_e.cls == 3'd7)) begin
                    fails++;
                    $display("FAIL out_illegal got=%b want=%b", iss.out_illegal, mon_e.cls == 3'd7);
                end
`endif
            end
        end
    end

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL send_timeout inst=%h in_ready=%b want 1", inst, in_ready);
        end else begin
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(3);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain_before_reset pending=%0d want 0", q.size());
        end
        q.delete();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        wb_valid = 1'b0;
        iss.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int w;
        #2;
        tests++;
        if ({in_ready, iss.out_valid, iss.alu_a, iss.alu_b, iss.aluctr, iss.out_rs2, iss.out_imm,
             iss.out_pc, iss.out_rd, iss.out_rd_wen, iss.out_cls} !== '0) begin
            fails++;
            $display("FAIL reset_state ready=%b valid=%b a=%h b=%h want all 0",
                     in_ready, iss.out_valid, iss.alu_a, iss.alu_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready got=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        // park addi x1 in a stalled slot, then reset under it
        iss.out_ready = 1'b0;
        send(32'h00500093, 32'h8000_0000, mk(0, 5, 4'b0000, 0, 5, 32'h8000_0000, 1, 1, 0), w);
        in_valid = 1'b1;
        in_inst  = 32'h402081B3;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({iss.out_valid, in_ready} !== 2'b00) begin
            fails++;
            $display("FAIL reset_midstall valid=%b ready=%b want 0 0", iss.out_valid, in_ready);
        end
        q.delete();
        in_valid = 1'b0;
        iss.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // scoreboard must be empty: sub reading x1 issues at once
        send(32'h402081B3, 32'h8000_0010,
             mk(regs[1], regs[2], 4'b1000, regs[2], 0, 32'h8000_0010, 3, 1, 0), w);
        tests++;
        if (w != 0) begin
            fails++;
            $display("FAIL reset_clears_sb waited=%0d want 0", w);
        end
        do_reset();
    endtask

    task automatic test_addi();
        int w;
        send(32'h00500093, 32'h100, mk(0, 5, 4'b0000, 0, 5, 32'h100, 1, 1, 0), w);
        send(32'h00100013, 32'h104, mk(0, 1, 4'b0000, 0, 1, 32'h104, 0, 0, 0), w);
        send(32'h00000433, 32'h108, mk(0, 0, 4'b0000, 0, 0, 32'h108, 8, 1, 0), w);
        tests++;
        if (w != 0) begin
            fails++;
            $display("FAIL x0_never_pending waited=%0d want 0", w);
        end
        do_reset();
    endtask

    task automatic test_hazard();
        int w;
        send(32'h00500093, 32'h200, mk(0, 5, 4'b0000, 0, 5, 32'h200, 1, 1, 0), w);
        in_valid = 1'b1;
        in_inst  = 32'h402081B3;
        in_pc    = 32'h204;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL raw_stall cyc%0d in_ready=%b want 0", i, in_ready);
            end
        end
        @(posedge clk);
        #1;
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL wb_no_bypass in_ready=%b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        send(32'h402081B3, 32'h204, mk(regs[1], regs[2], 4'b1000, regs[2], 0, 32'h204, 3, 1, 0), w);
        tests++;
        if (w != 0) begin
            fails++;
            $display("FAIL issue_after_wb waited=%0d want 0", w);
        end
        do_reset();
    endtask

    task automatic test_set_wins();
        int w;
        wb_valid = 1'b1;
        wb_rd    = 5'd6;
        send(32'h00700313, 32'h300, mk(0, 7, 4'b0000, 0, 7, 32'h300, 6, 1, 0), w);
        wb_valid = 1'b0;
        in_valid = 1'b1;
        in_inst  = 32'h00030393;
        in_pc    = 32'h304;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL set_wins in_ready=%b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        wb_valid = 1'b1;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        send(32'h00030393, 32'h304, mk(regs[6], 0, 4'b0000, 0, 0, 32'h304, 7, 1, 0), w);
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [5];
        exp_t        exps  [5];
        int          w;
        insts[0] = 32'hFE20AE23;
        exps[0]  = mk(regs[1], 32'hFFFFFFFC, 4'b0000, regs[2], 32'hFFFFFFFC, 32'h400, 28, 0, 2);
        insts[1] = 32'hFE20ECE3;
        exps[1]  = mk(regs[1], regs[2], 4'b1010, regs[2], 32'hFFFFFFF8, 32'h404, 25, 0, 3);
        insts[2] = 32'h40325213;
        exps[2]  = mk(regs[4], 3, 4'b1101, 0, 3, 32'h408, 4, 1, 0);
        insts[3] = 32'h123452B7;
        exps[3]  = mk(0, 32'h12345000, 4'b0011, 0, 32'h12345000, 32'h40C, 5, 1, 0);
        insts[4] = 32'h008000EF;
        exps[4]  = mk(32'h410, 4, 4'b0000, 0, 8, 32'h410, 1, 1, 4);
        for (int i = 0; i < 5; i++) begin
            send(insts[i], 32'h400 + 32'(i * 4), exps[i], w);
            tests++;
            if (w != 0) begin
                fails++;
                $display("FAIL back_to_back op%0d waited=%0d want 0", i, w);
            end
        end
        do_reset();
    endtask

    task automatic test_backpressure();
        int w;
        iss.out_ready = 1'b0;
        send(32'h00500093, 32'h500, mk(0, 5, 4'b0000, 0, 5, 32'h500, 1, 1, 0), w);
        in_valid = 1'b1;
        in_inst  = 32'h123452B7;
        in_pc    = 32'h504;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({in_ready, iss.out_valid, iss.alu_b, iss.out_rd, iss.out_pc} !==
                {1'b0, 1'b1, 32'd5, 5'd1, 32'h500}) begin
                fails++;
                $display("FAIL backpressure cyc%0d ready=%b valid=%b b=%h rd=%0d pc=%h want 0 1 5 1 500",
                         i, in_ready, iss.out_valid, iss.alu_b, iss.out_rd, iss.out_pc);
            end
        end
        @(posedge clk);
        #1;
        iss.out_ready = 1'b1;
        send(32'h123452B7, 32'h504, mk(0, 32'h12345000, 4'b0011, 0, 32'h12345000, 32'h504, 5, 1, 0), w);
        tests++;
        if (w != 0) begin
            fails++;
            $display("FAIL release_issue waited=%0d want 0", w);
        end
        do_reset();
    endtask

    task automatic test_illegal();
        int w;
        send(32'hFFFFFFFF, 32'h600, mk(0, 0, 4'b0000, 0, 0, 32'h600, 0, 0, ILL_CLS), w);
`ifdef IDU_ILLEGAL_TRAP_EN
        in_valid = 1'b1;
        in_inst  = 32'h00500093;
        in_pc    = 32'h604;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL trap_lock cyc%0d in_ready=%b want 0", i, in_ready);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`else
        send(32'h00500093, 32'h604, mk(0, 5, 4'b0000, 0, 5, 32'h604, 1, 1, 0), w);
        tests++;
        if (w != 0) begin
            fails++;
            $display("FAIL nop_no_lockup waited=%0d want 0", w);
        end
`endif
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h101;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_inst  = 32'h0;
        in_pc    = 32'h0;
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        iss.out_ready = 1'b1;
        test_reset();
        test_addi();
        test_hazard();
        test_set_wins();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
